// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with a TX FIFO and an RX FIFO.
//
// Ports
//   clk        system clock; all logic on its rising edge
//   rst        synchronous active-low reset
//   denv, wr   TX character and one-cycle push strobe (dropped when tx_full)
//   rd, drec   RX pop strobe; drec holds the last popped character
//   rxd, txd   serial input (asynchronous) and serial output (idle high)
//   tx_full, tx_empty, rx_full, rx_empty   registered FIFO status
//   tx_busy    high while a TX frame is on the line
//   rx_overrun, frame_err, parity_err      sticky, cleared by an accepted rd
//
// Frame: start 0, data LSB first, optional parity bit, stop_bits high bits.
module uart_fifo_core #(
  parameter int unsigned clk_freq   = 50000000,
  parameter int unsigned baud       = 115200,
  parameter int unsigned data_bits  = 8,
  parameter int unsigned fifo_depth = 16,
  parameter int unsigned parity     = 0,
  parameter int unsigned stop_bits  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_bits-1:0] denv,
  input  logic                 wr,
  input  logic                 rd,
  output logic [data_bits-1:0] drec,
  input  logic                 rxd,
  output logic                 txd,
  output logic                 tx_full,
  output logic                 tx_empty,
  output logic                 rx_full,
  output logic                 rx_empty,
  output logic                 tx_busy,
  output logic                 rx_overrun,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned Div  = clk_freq / baud;
  localparam int unsigned Half = Div / 2;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned AW   = $clog2(fifo_depth);

  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [AW:0]     PtrOne  = (AW + 1)'(1);
  localparam logic [3:0]      DataLast = 4'(data_bits - 1);
  localparam logic [3:0]      StopLast = 4'(stop_bits - 1);
  localparam logic            ParEn   = (parity != 0);
  localparam logic            ParOdd  = (parity == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------------------------------------------------------- TX FIFO
  logic [data_bits-1:0] tx_mem_q [fifo_depth];
  logic [AW:0]          tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic                 tx_full_q, tx_empty_q;
  logic                 tx_push, tx_pop;
  logic [data_bits-1:0] tx_head;
  logic                 tx_head_par;

  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
  assign tx_push     = wr && (!tx_full_q || tx_pop);
  assign tx_wptr_d   = tx_push ? tx_wptr_q + PtrOne : tx_wptr_q;
  assign tx_rptr_d   = tx_pop  ? tx_rptr_q + PtrOne : tx_rptr_q;
  assign tx_head     = tx_mem_q[tx_rptr_q[AW-1:0]];
  assign tx_head_par = (^tx_head) ^ ParOdd;

  // ---------------------------------------------------------------- TX FSM
  state_e               tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [data_bits-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt_q == CntLast);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + CntOne;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    txd        = 1'b1;
    case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (!tx_empty_q) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_par_d   = tx_head_par;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        txd = 1'b0;
        if (tx_tick) begin
          tx_bit_d   = '0;
          tx_state_d = StData;
        end
      end
      StData: begin
        txd = tx_shift_q[0];
        if (tx_tick) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == DataLast) begin
            tx_bit_d   = '0;
            tx_state_d = ParEn ? StParity : StStop;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      StParity: begin
        txd = tx_par_q;
        if (tx_tick) begin
          tx_bit_d   = '0;
          tx_state_d = StStop;
        end
      end
      StStop: begin
        txd = 1'b1;
        if (tx_tick) begin
          if (tx_bit_q == StopLast) begin
            // Chain straight into the next frame so back-to-back frames have no gap.
            if (!tx_empty_q) begin
              tx_pop     = 1'b1;
              tx_shift_d = tx_head;
              tx_par_d   = tx_head_par;
              tx_state_d = StStart;
            end else begin
              tx_state_d = StIdle;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  assign tx_busy = (tx_state_q != StIdle);

  // ---------------------------------------------------------------- RX path
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  state_e               rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [data_bits-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_tick, rx_wr, rx_ferr_new, rx_perr_new;

  assign rx_tick = (rx_cnt_q == CntLast);

  // START waits half a bit; every later sample is one full bit after the previous,
  // so each bit is sampled at its midpoint.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_tick ? '0 : rx_cnt_q + CntOne;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_perr_d   = rx_perr_q;
    rx_wr       = 1'b0;
    rx_ferr_new = 1'b0;
    rx_perr_new = 1'b0;
    case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_perr_d  = 1'b0;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_tick) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[data_bits-1:1]};
          if (rx_bit_q == DataLast) begin
            rx_state_d = ParEn ? StParity : StStop;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (rx_tick) begin
          rx_perr_d  = (rx_sync_q != ((^rx_shift_q) ^ ParOdd));
          rx_state_d = StStop;
        end
      end
      StStop: begin
        // Only the first stop bit is checked; any second one is just idle line.
        if (rx_tick) begin
          rx_wr       = 1'b1;
          rx_ferr_new = !rx_sync_q;
          rx_perr_new = rx_perr_q;
          rx_state_d  = StIdle;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [data_bits-1:0] rx_mem_q [fifo_depth];
  logic [AW:0]          rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic                 rx_full_q, rx_empty_q;
  logic                 rx_push, rx_pop;
  logic [data_bits-1:0] drec_q, drec_d;
  logic                 ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;

  assign rx_pop    = rd && !rx_empty_q;
  assign rx_push   = rx_wr && (!rx_full_q || rx_pop);
  assign rx_wptr_d = rx_push ? rx_wptr_q + PtrOne : rx_wptr_q;
  assign rx_rptr_d = rx_pop  ? rx_rptr_q + PtrOne : rx_rptr_q;
  assign drec_d    = rx_pop  ? rx_mem_q[rx_rptr_q[AW-1:0]] : drec_q;

  // Sticky flags: cleared by an accepted rd, but a new error in that cycle wins.
  assign ovr_d  = (ovr_q  && !rx_pop) || (rx_wr && !rx_push);
  assign ferr_d = (ferr_q && !rx_pop) || rx_ferr_new;
  assign perr_d = (perr_q && !rx_pop) || rx_perr_new;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_full_q  <= 1'b0;
      tx_empty_q <= 1'b1;
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_full_q  <= 1'b0;
      rx_empty_q <= 1'b1;
      drec_q     <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_full_q  <= (tx_wptr_d[AW] != tx_rptr_d[AW]) &&
                    (tx_wptr_d[AW-1:0] == tx_rptr_d[AW-1:0]);
      tx_empty_q <= (tx_wptr_d == tx_rptr_d);
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      rx_meta_q  <= rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_full_q  <= (rx_wptr_d[AW] != rx_rptr_d[AW]) &&
                    (rx_wptr_d[AW-1:0] == rx_rptr_d[AW-1:0]);
      rx_empty_q <= (rx_wptr_d == rx_rptr_d);
      drec_q     <= drec_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= denv;
    if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_shift_q;
  end

  assign tx_full    = tx_full_q;
  assign tx_empty   = tx_empty_q;
  assign rx_full    = rx_full_q;
  assign rx_empty   = rx_empty_q;
  assign drec       = drec_q;
  assign rx_overrun = ovr_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core at div = 50.
//   dut 0: defaults (8N1, depth 16), txd looped to rxd
//   dut 1: even parity, depth 4, rxd from bench driver or looped from its txd
//   dut 2: odd parity, depth 16, txd looped to rxd
module tb_uart_fifo_core;

  localparam int unsigned ClkFreq = 50000000;
  localparam int unsigned Baud    = 1000000;
  localparam int unsigned Div     = ClkFreq / Baud;
  localparam int unsigned Half    = Div / 2;

  logic       clk = 1'b0;
  logic       rst_a      [3];
  logic       wr_a       [3];
  logic       rd_a       [3];
  logic [7:0] denv_a     [3];
  logic [7:0] drec_a     [3];
  logic       txd_a      [3];
  logic       tx_full_a  [3];
  logic       tx_empty_a [3];
  logic       rx_full_a  [3];
  logic       rx_empty_a [3];
  logic       tx_busy_a  [3];
  logic       ovr_a      [3];
  logic       ferr_a     [3];
  logic       perr_a     [3];
  logic       rxd_drv, loop_ev;
  wire        rxd_def = txd_a[0];
  wire        rxd_ev  = loop_ev ? txd_a[1] : rxd_drv;
  wire        rxd_od  = txd_a[2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_fifo_core #(.clk_freq(ClkFreq), .baud(Baud)) u_def (
    .clk(clk), .rst(rst_a[0]), .denv(denv_a[0]), .wr(wr_a[0]), .rd(rd_a[0]),
    .drec(drec_a[0]), .rxd(rxd_def), .txd(txd_a[0]), .tx_full(tx_full_a[0]),
    .tx_empty(tx_empty_a[0]), .rx_full(rx_full_a[0]), .rx_empty(rx_empty_a[0]),
    .tx_busy(tx_busy_a[0]), .rx_overrun(ovr_a[0]), .frame_err(ferr_a[0]),
    .parity_err(perr_a[0])
  );

  uart_fifo_core #(.clk_freq(ClkFreq), .baud(Baud), .fifo_depth(4), .parity(1)) u_even (
    .clk(clk), .rst(rst_a[1]), .denv(denv_a[1]), .wr(wr_a[1]), .rd(rd_a[1]),
    .drec(drec_a[1]), .rxd(rxd_ev), .txd(txd_a[1]), .tx_full(tx_full_a[1]),
    .tx_empty(tx_empty_a[1]), .rx_full(rx_full_a[1]), .rx_empty(rx_empty_a[1]),
    .tx_busy(tx_busy_a[1]), .rx_overrun(ovr_a[1]), .frame_err(ferr_a[1]),
    .parity_err(perr_a[1])
  );

  uart_fifo_core #(.clk_freq(ClkFreq), .baud(Baud), .parity(2)) u_odd (
    .clk(clk), .rst(rst_a[2]), .denv(denv_a[2]), .wr(wr_a[2]), .rd(rd_a[2]),
    .drec(drec_a[2]), .rxd(rxd_od), .txd(txd_a[2]), .tx_full(tx_full_a[2]),
    .tx_empty(tx_empty_a[2]), .rx_full(rx_full_a[2]), .rx_empty(rx_empty_a[2]),
    .tx_busy(tx_busy_a[2]), .rx_overrun(ovr_a[2]), .frame_err(ferr_a[2]),
    .parity_err(perr_a[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {txd, tx_empty, rx_empty, tx_full, rx_full, tx_busy, overrun, frame_err, parity_err}
  function automatic logic [8:0] status(input int sel);
    return {txd_a[sel], tx_empty_a[sel], rx_empty_a[sel], tx_full_a[sel], rx_full_a[sel],
            tx_busy_a[sel], ovr_a[sel], ferr_a[sel], perr_a[sel]};
  endfunction

  task automatic push1(input int sel, input logic [7:0] d);
    @(negedge clk);
    wr_a[sel]   = 1'b1;
    denv_a[sel] = d;
    @(negedge clk);
    wr_a[sel]   = 1'b0;
  endtask

  // drec reflects the popped head on return.
  task automatic pop1(input int sel);
    @(negedge clk);
    rd_a[sel] = 1'b1;
    @(negedge clk);
    rd_a[sel] = 1'b0;
  endtask

  // Software receiver on txd of one dut (all decoded duts carry a parity bit).
  task automatic watch_tx(input int sel, output logic [7:0] data, output logic pbit,
                          output logic sbit, output logic found);
    found = 1'b0;
    data  = '0;
    pbit  = 1'b0;
    sbit  = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (txd_a[sel] == 1'b0) found = 1'b1;
    end
    if (found) begin
      repeat (Half) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (Div) @(negedge clk);
        data[b] = txd_a[sel];
      end
      repeat (Div) @(negedge clk);
      pbit = txd_a[sel];
      repeat (Div) @(negedge clk);
      sbit = txd_a[sel];
    end
  endtask

  // Even-parity frame into u_even, with optional parity and stop corruption.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_val);
    rxd_drv = 1'b0;
    repeat (Div) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rxd_drv = d[b];
      repeat (Div) @(negedge clk);
    end
    rxd_drv = (^d) ^ bad_par;
    repeat (Div) @(negedge clk);
    rxd_drv = stop_val;
    repeat (Div) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (Div) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, vals [6];
    logic       pb, sb, found;
    int         cnt;
    logic       low_seen;

    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b0; wr_a[i] = 1'b0; rd_a[i] = 1'b0; denv_a[i] = '0;
    end
    rxd_drv = 1'b1;
    loop_ev = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_status", 32'(status(i)), 32'h1C0);
      check_eq("rst_drec", 32'(drec_a[i]), 32'h0);
    end
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b1;
    repeat (2) @(negedge clk);

    // Four back-to-back loopback frames on dut 0.
    vals[0] = 8'h05; vals[1] = 8'h0A; vals[2] = 8'h0F; vals[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_a[0]   = 1'b1;
      denv_a[0] = vals[i];
    end
    @(negedge clk);
    wr_a[0] = 1'b0;
    // Busy since the edge after the first push: two high samples precede this one.
    cnt = 0;
    for (int i = 0; i < 5000 && tx_busy_a[0]; i++) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("busy_run", 32'(cnt + 2), 32'd2000);
    repeat (50) @(negedge clk);
    check_eq("lb_rx_nonempty", 32'(rx_empty_a[0]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      pop1(0);
      check_eq("lb_drec", 32'(drec_a[0]), 32'(vals[i]));
    end
    check_eq("lb_rx_empty", 32'(rx_empty_a[0]), 32'h1);
    check_eq("lb_no_err", 32'({ovr_a[0], ferr_a[0], perr_a[0]}), 32'h0);

    // Reset in TX data bit 3 of dut 0 aborts the frame and drops the queued one.
    @(negedge clk);
    wr_a[0] = 1'b1; denv_a[0] = 8'h55;
    @(negedge clk);
    denv_a[0] = 8'h66;
    @(negedge clk);
    wr_a[0] = 1'b0;
    repeat (210) @(negedge clk);
    rst_a[0] = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_txd", 32'(txd_a[0]), 32'h1);
    check_eq("mid_rst_txe", 32'(tx_empty_a[0]), 32'h1);
    check_eq("mid_rst_busy", 32'(tx_busy_a[0]), 32'h0);
    check_eq("mid_rst_drec", 32'(drec_a[0]), 32'h0);
    rst_a[0] = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (txd_a[0] == 1'b0) low_seen = 1'b1;
    end
    check_eq("no_frame_after_rst", 32'(low_seen), 32'h0);
    check_eq("partial_rx_dropped", 32'(rx_empty_a[0]), 32'h1);

    // Even parity loopback: parity bit of 0x07 is 1.
    push1(1, 8'h07);
    watch_tx(1, d, pb, sb, found);
    check_eq("ev_found", 32'(found), 32'h1);
    check_eq("ev_data", 32'(d), 32'h07);
    check_eq("ev_pbit", 32'(pb), 32'h1);
    check_eq("ev_stop", 32'(sb), 32'h1);
    repeat (40) @(negedge clk);
    check_eq("ev_no_perr", 32'(perr_a[1]), 32'h0);
    pop1(1);
    check_eq("ev_lb_drec", 32'(drec_a[1]), 32'h07);

    // Odd parity loopback: parity bit of 0x07 is 0.
    push1(2, 8'h07);
    watch_tx(2, d, pb, sb, found);
    check_eq("od_found", 32'(found), 32'h1);
    check_eq("od_data", 32'(d), 32'h07);
    check_eq("od_pbit", 32'(pb), 32'h0);
    repeat (40) @(negedge clk);
    check_eq("od_no_perr", 32'(perr_a[2]), 32'h0);
    pop1(2);
    check_eq("od_lb_drec", 32'(drec_a[2]), 32'h07);

    // Bench-driven frames into u_even.
    loop_ev = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    check_eq("perr_set", 32'(perr_a[1]), 32'h1);
    check_eq("perr_no_ferr", 32'(ferr_a[1]), 32'h0);
    pop1(1);
    check_eq("perr_drec", 32'(drec_a[1]), 32'h07);
    check_eq("perr_cleared", 32'(perr_a[1]), 32'h0);

    send_frame(8'h3C, 1'b0, 1'b0);
    check_eq("ferr_set", 32'(ferr_a[1]), 32'h1);
    check_eq("ferr_stored", 32'(rx_empty_a[1]), 32'h0);
    pop1(1);
    check_eq("ferr_drec", 32'(drec_a[1]), 32'h3C);
    check_eq("ferr_cleared", 32'(ferr_a[1]), 32'h0);

    rxd_drv = 1'b0;
    repeat (10) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (600) @(negedge clk);
    check_eq("glitch_nothing", 32'(rx_empty_a[1]), 32'h1);

    // Overrun: depth 4, five frames, no reads in between.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1);
    check_eq("ovr_full4", 32'(rx_full_a[1]), 32'h1);
    check_eq("ovr_not_yet", 32'(ovr_a[1]), 32'h0);
    send_frame(8'h05, 1'b0, 1'b1);
    check_eq("ovr_set", 32'(ovr_a[1]), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      pop1(1);
      check_eq("ovr_drec", 32'(drec_a[1]), 32'(i));
      if (i == 1) check_eq("ovr_cleared", 32'(ovr_a[1]), 32'h0);
    end
    check_eq("ovr_rx_empty", 32'(rx_empty_a[1]), 32'h1);
    pop1(1);
    check_eq("empty_rd_hold", 32'(drec_a[1]), 32'h04);

    // Push into a full TX FIFO is dropped: 0xAA must never go out.
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    vals[3] = 8'h44; vals[4] = 8'h55; vals[5] = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_a[1]   = 1'b1;
      denv_a[1] = vals[i];
    end
    @(negedge clk);
    wr_a[1] = 1'b0;
    check_eq("tx_full", 32'(tx_full_a[1]), 32'h1);
    for (int i = 0; i < 5; i++) begin
      watch_tx(1, d, pb, sb, found);
      check_eq("full_found", 32'(found), 32'h1);
      check_eq("full_data", 32'(d), 32'(vals[i]));
    end
    watch_tx(1, d, pb, sb, found);
    check_eq("no_aa_frame", 32'(found), 32'h0);
    check_eq("tx_drained", 32'(tx_empty_a[1]), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_fifo_core.md
UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 SHALL have parameter clk_freq, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baud, default 115200, line bit rate in bit/s.
REQ-003 SHALL have parameter data_bits, default 8, character width, legal range 5..9.
REQ-004 SHALL have parameter fifo_depth, default 16, entries per FIFO, power of two, at least 2.
REQ-005 SHALL have parameter parity, default 0: 0 = none, 1 = even, 2 = odd.
REQ-006 SHALL have parameter stop_bits, default 1, legal values 1 or 2.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 denv  in  data_bits  TX character to enqueue.
REQ-010 wr  in  1  one-cycle push strobe for denv.
REQ-011 rd  in  1  one-cycle pop strobe for the RX FIFO.
REQ-012 drec  out  data_bits  last popped RX character, registered.
REQ-013 rxd  in  1  asynchronous serial input.
REQ-014 txd  out  1  serial output, idle high.
REQ-015 tx_full, tx_empty, rx_full, rx_empty  out  1 each  FIFO status, registered.
REQ-016 tx_busy  out  1  high while a TX frame is on the line.
REQ-017 rx_overrun, frame_err, parity_err  out  1 each  sticky error flags.

Function
REQ-018 Bit period SHALL be div = clk_freq/baud, truncated, with a separate counter for TX and for RX.
REQ-019 Frame order SHALL be: start bit 0, data LSB first, optional parity bit, then stop_bits high bits.
REQ-020 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP.
  - In IDLE with the TX FIFO not empty: pop one entry and enter START on the next cycle.
  - PARITY is skipped when parity = 0.
  - After the last stop bit, return to IDLE; back-to-back frames add no idle gap.
REQ-021 A push with wr=1 while tx_full=1 SHALL be discarded, leaving FIFO contents unchanged.
  - If wr coincides with a TX pop on a full FIFO, the push is accepted.
REQ-022 rxd SHALL pass through a 2-flop synchroniser before any use.
REQ-023 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP, sampling each bit at div/2 into its bit period.
  - A falling edge in IDLE enters START.
  - If rxd is high at the START midpoint, treat it as a glitch and return to IDLE with nothing stored.
REQ-024 At the STOP midpoint the character SHALL be written to the RX FIFO, and the FSM returns to IDLE.
  - If the stop sample is 0: still store the character and set frame_err.
  - If the parity mismatches: still store the character and set parity_err.
  - With stop_bits = 2, RX checks only the first stop bit.
REQ-025 If the RX FIFO is full when a character completes, the character SHALL be dropped and rx_overrun set.
REQ-026 On rd=1 with rx_empty=0, drec SHALL show the head entry on the cycle after rd, and the entry is removed.
  - rd with rx_empty=1 is ignored, and drec holds its value.
REQ-027 Simultaneous RX write and rd on a full FIFO SHALL both succeed with no overrun.
REQ-028 Sticky error flags SHALL clear on any accepted rd; a new error in that same cycle wins, so the flag stays set.
REQ-029 FIFO pointers SHALL carry one extra wrap bit.
  - Full: indices equal and wrap bits differ.
  - Empty: pointers equal.
  - Status outputs update the cycle after the causing strobe.
REQ-030 Parity for even mode SHALL be the XOR of the data bits; odd mode uses its inverse.

Reset
REQ-031 With rst=0 sampled at a clock edge, the following SHALL hold next cycle:
  - Both FSMs in IDLE, counters 0, both FIFOs emptied.
  - txd=1, drec=0, tx_empty=1, rx_empty=1.
  - tx_full=0, rx_full=0, tx_busy=0, all error flags 0.
REQ-032 Reset mid-frame SHALL abort the frame: txd goes high next cycle, and a partial RX character is discarded.

Verification
(Settings for all scenarios: clk_freq=50000000, baud=1000000, so div=50.)
REQ-033 Defaults, txd looped to rxd; push 0x05, 0x0A, 0x0F, 0xFF -> four 500-cycle frames back to back, then four rd give drec 0x05, 0x0A, 0x0F, 0xFF.
REQ-034 parity=1; push 0x07 -> parity bit 1 on txd; parity=2 -> parity bit 0; loopback raises no parity_err. Then force a wrong parity bit on rxd -> parity_err=1, cleared by the next rd.
REQ-035 fifo_depth=4, with no rd: deliver 5 frames on rxd -> rx_full=1 after 4, rx_overrun=1 after the 5th, and reads return the first 4 characters only.
REQ-036 Drive rxd with stop bit 0 for data 0x3C -> frame_err=1 and 0x3C stored; a 10-cycle low glitch on rxd -> nothing stored.
REQ-037 Assert rst=0 at TX data bit 3 -> txd=1 next cycle, tx_empty=1, tx_busy=0, and no further frame is sent.
REQ-038 With tx_full=1, pulse wr with 0xAA -> 0xAA never appears on txd.
